// File: rtl/updown_counter_mod.sv
// Up/down counter with runtime modulus, wrap/saturate mode, enable prescaler,
// one-cycle terminal-count pulse and sticky overflow flag.
module updown_counter_mod #(
  parameter int WIDTH      = 8,
  parameter int PRESCALE_W = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr,
  input  logic                  load,
  input  logic [WIDTH-1:0]      data_in,
  input  logic                  enable,
  input  logic                  up_down,
  input  logic                  sat_mode,
  input  logic [WIDTH-1:0]      limit,
  input  logic [PRESCALE_W-1:0] prescale,
  output logic [WIDTH-1:0]      count_out,
  output logic                  tc,
  output logic                  ovf
);

  logic [PRESCALE_W-1:0] pre_cnt;
  logic [PRESCALE_W-1:0] pre_next;
  logic                  tick;
  logic                  boundary;
  logic [WIDTH-1:0]      count_next;

  // Prescaler: pre_cnt free-wraps, so lowering prescale below pre_cnt delays
  // the next tick until the counter comes round through its full range.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    tick     = 1'b0;
    pre_next = pre_cnt;
    if (enable) begin
      if (pre_cnt == prescale) begin
        tick     = 1'b1;
        pre_next = '0;
      end else begin
        pre_next = pre_cnt + PRESCALE_W'(1);
      end
    end
  end

  // Step value for a tick; out-of-range loaded values count as being at the top.
  always_comb begin
    boundary   = 1'b0;
    count_next = count_out;
    if (up_down) begin
      if (count_out < limit) begin
        count_next = count_out + WIDTH'(1);
      end else begin
        boundary   = 1'b1;
        count_next = sat_mode ? limit : '0;
      end
    end else begin
      if (count_out != '0) begin
        count_next = count_out - WIDTH'(1);
      end else begin
        boundary   = 1'b1;
        count_next = sat_mode ? '0 : limit;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_out <= '0;
      pre_cnt   <= '0;
      tc        <= 1'b0;
      ovf       <= 1'b0;
    end else if (clr) begin
      count_out <= '0;
      pre_cnt   <= '0;
      tc        <= 1'b0;
      ovf       <= 1'b0;
    end else if (load) begin
      // A tick coinciding with load is discarded; ovf is deliberately kept.
      count_out <= data_in;
      pre_cnt   <= '0;
      tc        <= 1'b0;
    end else begin
      pre_cnt <= pre_next;
      tc      <= tick && boundary;
      if (tick) begin
        count_out <= count_next;
        if (boundary) begin
          ovf <= 1'b1;
        end
      end
    end
  end

endmodule
